// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative binary-to-BCD converter (shift-and-add-3).
// One input bit is consumed per clock. Results (bcd, blank, ovf) are
// registered together with a one-cycle done pulse and then held until
// the next completion or reset.
module bin2bcd_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  ovf
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  // All digits blanked except digit 0 (what the value zero displays as).
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1'b1);

  // Add 3 to every digit that is 5 or more so the following shift carries
  // correctly into the next decimal digit. Max result 12 fits in 4 bits.
  function automatic logic [ACC_W-1:0] add3(input logic [ACC_W-1:0] a);
    logic [ACC_W-1:0] r;
    r = a;
    for (int k = 0; k < DIGITS; k++) begin
      if (a[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = a[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = a[4*k +: 4];
      end
    end
    return r;
  endfunction

  // Leading-zero mask: a digit is flagged while it and every more
  // significant digit are zero. Digit 0 is never flagged.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [ACC_W-1:0] v);
    logic [DIGITS-1:0] m;
    logic              zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (v[4*k +: 4] == 4'd0);
      m[k]       = zero_above;
    end
    return m;
  endfunction

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [BIN_W-1:0]  sh_q,    sh_d;
  logic [ACC_W-1:0]  acc_q,   acc_d;
  logic              ovf_acc_q, ovf_acc_d;
  logic [ACC_W-1:0]  adj_s;
  logic              last_s;

  logic              done_q;
  logic [ACC_W-1:0]  bcd_q;
  logic [DIGITS-1:0] blank_q;
  logic              ovf_q;

  // Next-state logic: accept a request in IDLE, one correction+shift per SHIFT cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    acc_d     = acc_q;
    ovf_acc_d = ovf_acc_q;
    last_s    = 1'b0;
    adj_s     = add3(acc_q);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_SHIFT;
          sh_d      = bin;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = CNT_W'(BIN_W);
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_SHIFT: begin
        // MSB of the binary operand enters digit 0 bit 0; the carry out of
        // the top digit is a multiple of 10^DIGITS and is only recorded.
        {acc_d, sh_d} = {adj_s[ACC_W-2:0], sh_q, 1'b0};
        ovf_acc_d     = ovf_acc_q | adj_s[ACC_W-1];
        cnt_d         = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          last_s  = 1'b1;
        end else begin
          state_d = S_SHIFT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath and FSM registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      acc_q     <= '0;
      ovf_acc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      acc_q     <= acc_d;
      ovf_acc_q <= ovf_acc_d;
    end
  end

  // Result registers: loaded only on the final shift so no partial value is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q  <= 1'b0;
      bcd_q   <= '0;
      blank_q <= BLANK_RST;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= last_s;
      if (last_s) begin
        bcd_q   <= acc_d;
        blank_q <= blank_mask(acc_d);
        ovf_q   <= ovf_acc_d;
      end else begin
        bcd_q   <= bcd_q;
        blank_q <= blank_q;
        ovf_q   <= ovf_q;
      end
    end
  end

  assign busy  = (state_q == S_SHIFT);
  assign done  = done_q;
  assign bcd   = bcd_q;
  assign blank = blank_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: three parameterisations, a
// divide/modulo reference model and per-instance scoreboards.
module tb_bin2bcd_seq;

  typedef struct {
    longint unsigned v;
    int              due;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_fail;

  // u0: 32 bit / 10 digits, u1: 32 bit / 8 digits, u2: 4 bit / 2 digits
  logic        start0, start1, start2;
  logic [31:0] bin0, bin1;
  logic [3:0]  bin2;
  logic        busy0, busy1, busy2;
  logic        done0, done1, done2;
  logic [39:0] bcd0;
  logic [31:0] bcd1;
  logic [7:0]  bcd2;
  logic [9:0]  blank0;
  logic [7:0]  blank1;
  logic [1:0]  blank2;
  logic        ovf0, ovf1, ovf2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t e0, e1, e2;

  bin2bcd_seq #(.BIN_W(32), .DIGITS(10)) u0 (
    .clk(clk), .rst(rst), .start(start0), .bin(bin0), .busy(busy0),
    .done(done0), .bcd(bcd0), .blank(blank0), .ovf(ovf0));

  bin2bcd_seq #(.BIN_W(32), .DIGITS(8)) u1 (
    .clk(clk), .rst(rst), .start(start1), .bin(bin1), .busy(busy1),
    .done(done1), .bcd(bcd1), .blank(blank1), .ovf(ovf1));

  bin2bcd_seq #(.BIN_W(4), .DIGITS(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .bin(bin2), .busy(busy2),
    .done(done2), .bcd(bcd2), .blank(blank2), .ovf(ovf2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: decimal digits by division, truncated to 'digits' digits.
  task automatic model(input longint unsigned v, input int digits,
                       output logic [63:0] bcd, output logic [15:0] blank,
                       output logic ovf);
    longint unsigned pw;
    longint unsigned t;
    bool_loop: begin end
    pw = 1;
    for (int i = 0; i < digits; i++) pw = pw * 10;
    ovf   = (v >= pw);
    t     = v % pw;
    bcd   = '0;
    blank = '0;
    for (int i = 0; i < digits; i++) begin
      bcd[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    for (int k = digits - 1; k >= 1; k--) begin
      if (bcd[4*k +: 4] != 4'd0) break;
      blank[k] = 1'b1;
    end
  endtask

  task automatic score(input string tag, input exp_t e, input int digits,
                       input logic [63:0] bcd_got, input logic [15:0] blank_got,
                       input logic ovf_got);
    logic [63:0] xb;
    logic [15:0] xl;
    logic        xo;
    model(e.v, digits, xb, xl, xo);
    check({tag, "_done_cycle"}, 64'(cyc), 64'(e.due));
    check({tag, "_bcd"},        bcd_got,  xb);
    check({tag, "_blank"},      64'(blank_got), 64'(xl));
    check({tag, "_ovf"},        64'(ovf_got),   64'(xo));
  endtask

  // Scoreboard monitors: every done must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done0) begin
      if (q0.size() == 0) check("u0_unexpected_done", 64'(done0), 64'd0);
      else begin e0 = q0.pop_front(); score("u0", e0, 10, 64'(bcd0), 16'(blank0), ovf0); end
    end
    if (done1) begin
      if (q1.size() == 0) check("u1_unexpected_done", 64'(done1), 64'd0);
      else begin e1 = q1.pop_front(); score("u1", e1, 8, 64'(bcd1), 16'(blank1), ovf1); end
    end
    if (done2) begin
      if (q2.size() == 0) check("u2_unexpected_done", 64'(done2), 64'd0);
      else begin e2 = q2.pop_front(); score("u2", e2, 2, 64'(bcd2), 16'(blank2), ovf2); end
    end
  end

  function automatic logic sel_done(input int which);
    case (which)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  // Called #1 after a posedge with the DUT idle; start is held for one cycle.
  task automatic go(input int which, input longint unsigned v);
    exp_t e;
    e.v = v;
    case (which)
      0: begin e.due = cyc + 33; start0 = 1'b1; bin0 = v[31:0]; q0.push_back(e); end
      1: begin e.due = cyc + 33; start1 = 1'b1; bin1 = v[31:0]; q1.push_back(e); end
      default: begin e.due = cyc + 5; start2 = 1'b1; bin2 = v[3:0]; q2.push_back(e); end
    endcase
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  // Returns #1 after the posedge that raised done (i.e. inside the done cycle).
  task automatic wait_done(input int which);
    int   t;
    logic d;
    t = 0;
    d = sel_done(which);
    while (!d && t < 100) begin
      @(posedge clk); #1;
      t++;
      d = sel_done(which);
    end
    if (!d) check("done_timeout", 64'(d), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned r;
    n_chk = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    bin0 = '0; bin1 = '0; bin2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  64'(busy0),  64'd0);
    check("rst_done",  64'(done0),  64'd0);
    check("rst_bcd",   64'(bcd0),   64'd0);
    check("rst_blank", 64'(blank0), 64'(10'b1111111110));
    check("rst_ovf",   64'(ovf0),   64'd0);
    check("rst_blank_u2", 64'(blank2), 64'(2'b10));
    rst = 1'b0;

    // Basic conversion with busy profile and an ignored start mid-shift.
    go(0, 64'd12345678);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("u0_busy_shift", 64'(busy0), 64'd1);
      if (i == 5) begin start0 = 1'b1; bin0 = 32'd7; end
      if (i == 6) begin start0 = 1'b0; bin0 = 32'd0; end
    end
    wait_done(0);
    check("u0_busy_at_done", 64'(busy0), 64'd0);

    // Back-to-back starts issued in the done cycle.
    go(0, 64'd42);
    wait_done(0);
    go(0, 64'hFFFF_FFFF);
    wait_done(0);
    go(0, 64'd0);
    wait_done(0);
    for (int i = 0; i < 3; i++) begin
      r = longint'($urandom);
      go(0, r);
      wait_done(0);
    end

    // Reset in the middle of a conversion.
    @(posedge clk); #1;
    go(0, 64'd555555);
    repeat (8) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q0.delete();
    check("midrst_busy",  64'(busy0),  64'd0);
    check("midrst_done",  64'(done0),  64'd0);
    check("midrst_bcd",   64'(bcd0),   64'd0);
    check("midrst_blank", 64'(blank0), 64'(10'b1111111110));
    repeat (40) begin @(posedge clk); #1; end
    go(0, 64'd987654321);
    wait_done(0);

    // Overflow with 8 digits, then a clean conversion clears ovf.
    @(posedge clk); #1;
    go(1, 64'd123456789);
    wait_done(1);
    go(1, 64'd99999999);
    wait_done(1);
    go(1, 64'd100000000);
    wait_done(1);

    // Small generic instance: every 4-bit value, back-to-back.
    @(posedge clk); #1;
    go(2, 64'd15);
    wait_done(2);
    for (int v = 0; v < 16; v++) begin
      go(2, longint'(v));
      wait_done(2);
    end

    repeat (5) begin @(posedge clk); #1; end
    check("u0_queue_empty", 64'(q0.size()), 64'd0);
    check("u1_queue_empty", 64'(q1.size()), 64'd0);
    check("u2_queue_empty", 64'(q2.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Multi-cycle binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. One bit is processed per clock.
- Parametrised successor to the team's combinational hex-to-BCD block. Input width and digit count are generic.
- Adds a start/done handshake, an overflow flag and a leading-zero blanking mask for the score/seven-segment display path.
- Replaces the wide combinational divide/modulo chain with a small iterative datapath.

Parameters:
- BIN_W, 32, width of the binary input; legal range >= 1.
- DIGITS, 10, number of BCD output digits; legal range >= 1. 10 covers full 32-bit range.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  request a conversion of bin; sampled only when accepted (see Behaviour)
- bin  in  BIN_W  unsigned binary value; sampled in the cycle start is accepted
- busy  out  1  high while a conversion is shifting
- done  out  1  one-cycle pulse; bcd/blank/ovf updated in the same cycle
- bcd  out  4*DIGITS  packed BCD result; digit k at bits [4k+3:4k], digit 0 = least significant
- blank  out  DIGITS  bit k = 1 when digit k is a leading zero; bit 0 is always 0
- ovf  out  1  value >= 10^DIGITS; bcd then holds value mod 10^DIGITS

Behaviour:
- Interface is decided: one clock, clk; reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, ovf=0, bcd=0, blank = all ones except bit 0 = 0. FSM goes to IDLE. Reset has priority over everything, including mid-conversion; any in-flight conversion is aborted and produces no done.
- FSM states:
  - IDLE: busy=0.
  - SHIFT: busy=1.
- Accepting a request:
  - start is accepted when state is IDLE and rst=0, including the cycle in which done is high.
  - On acceptance: latch bin into the shift register, clear the internal BCD accumulator and internal ovf, load the bit counter with BIN_W, and go to SHIFT.
  - start while in SHIFT is ignored: no queueing, no effect on the current conversion.
- SHIFT, each cycle:
  - For every digit of the accumulator, add 3 if the digit is >= 5.
  - Shift the {accumulator, shift register} concatenation left by 1. The MSB of bin enters digit 0 bit 0.
  - If the bit shifted out of the top digit's MSB is 1, set internal ovf (sticky for this conversion).
  - Decrement the counter. When the counter reaches 0 after this shift, go to IDLE.
- Completion:
  - The cycle after the final shift, bcd is loaded from the accumulator and blank and ovf are registered. done=1 for exactly that cycle.
  - Latency: start accepted in cycle N, so done=1 in cycle N+BIN_W+1. Throughput is one conversion per BIN_W+1 cycles with back-to-back starts.
- Holding outputs: bcd, blank and ovf hold their values until the next done or reset. They never show partial results.
- blank computation: scan from digit DIGITS-1 downward. A digit is flagged while it and every more-significant digit are 0. Digit 0 is never flagged, so the value 0 displays as a single "0".
- Overflow: the discarded carries are multiples of 10^DIGITS. The truncated bcd is therefore exactly value mod 10^DIGITS. The blank mask is computed on that truncated value.
- Arithmetic: all digit corrections are 4-bit and no digit ever exceeds 9 after a shift. The counter width is clog2(BIN_W+1).
- Timing of bin: bin is don't-care outside the acceptance cycle.

Test Plan:
- Basic conversion. BIN_W=32, DIGITS=10, start with bin=12345678 at cycle 0 -> done pulses only at cycle 33; bcd=40'h0012345678; blank=10'b1100000000; ovf=0; busy high for cycles 1-32.
- Extremes.
  - bin=32'hFFFFFFFF -> bcd=40'h4294967295, blank=0, ovf=0.
  - bin=0 -> bcd=0, blank=10'b1111111110, ovf=0.
- Overflow. DIGITS=8, bin=123456789 -> bcd=32'h23456789, ovf=1, blank=8'b00000000. A following conversion of bin=99999999 -> ovf=0, bcd=32'h99999999.
- Handshake.
  - start pulses during SHIFT with a different bin -> ignored; result unchanged.
  - start asserted in the done cycle with bin=42 -> accepted; the next done comes 33 cycles later with bcd=40'h42 and blank=10'b1111111100.
- Reset mid-operation.
  - rst asserted at cycle 10 of a conversion -> next cycle busy=0, bcd=0, blank reset value, no done pulse.
  - A new start after reset converts correctly.
- Small generic. BIN_W=4, DIGITS=2, bin=4'd15 -> done 5 cycles after start; bcd=8'h15, blank=2'b00, ovf=0.
